// File: rtl/fetch_decode_if.sv
// Bundle of the fetch/decode stage's memory, downstream and redirect signals.
// master = the stage itself, slave = its environment (memory, control unit, execute).
//
// Handshake: the stage offers a decoded instruction by holding out_valid=1.
// A transfer happens on a rising edge where out_valid=1, out_ready=1 and
// branch_taken=0. While out_valid=1 and no transfer happens, every decoded
// field stays stable. imem_ack completes a fetch only on an edge where
// imem_req=1 and branch_taken=0.
interface fetch_decode_if #(
  parameter int PC_W = 8,
  parameter int IW   = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [IW-1:0]   imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      opcode;
  logic [2:0]      rd;
  logic [2:0]      rs1;
  logic [2:0]      rs2;
  logic [7:0]      imm;
  logic [PC_W-1:0] pc_out;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic [15:0]     instr_count;
  logic            state_dbg;

  modport master (
    output imem_req, imem_addr, out_valid, opcode, rd, rs1, rs2, imm,
           pc_out, instr_count, state_dbg,
    input  imem_ack, imem_rdata, out_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, opcode, rd, rs1, rs2, imm,
           pc_out, instr_count, state_dbg,
    output imem_ack, imem_rdata, out_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_decode_stage.sv
// Two-state fetch/decode stage: requests one instruction word, holds it decoded
// until downstream takes it, and accepts branch redirects from execute.
module fetch_decode_stage #(
  parameter int PC_W = 8,
  parameter int IW   = 16
) (
  input  logic           clk,
  input  logic           rst,
  fetch_decode_if.master bus
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_held;
  logic [IW-1:0]   ir;
  logic [15:0]     count;
  logic            take;
  logic            handoff;

  // A redirect overrides both a returning fetch and a downstream handoff.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    handoff   = 1'b0;
    if (bus.branch_taken) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        FETCH: if (bus.imem_ack) begin
          state_nxt = HOLD;
          take      = 1'b1;
        end
        HOLD: if (bus.out_ready) begin
          state_nxt = FETCH;
          handoff   = 1'b1;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      pc_held <= '0;
      ir      <= '0;
    end else begin
      if (bus.branch_taken) begin
        pc <= bus.branch_target;
      end else if (take) begin
        pc <= pc + 1'b1;
      end
      if (take) begin
        ir      <= bus.imem_rdata;
        pc_held <= pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (handoff && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  assign bus.imem_req    = (state == FETCH);
  assign bus.out_valid   = (state == HOLD);
  assign bus.imem_addr   = pc;
  assign bus.pc_out      = pc_held;
  assign bus.instr_count = count;
  assign bus.state_dbg   = state;

  // Field positions assume a 16-bit instruction word.
  assign bus.opcode = ir[15:13];
  assign bus.rd     = ir[12:10];
  assign bus.rs1    = ir[9:7];
  assign bus.rs2    = ir[6:4];
  assign bus.imm    = ir[7:0];

endmodule
